sys_bus_initiator: RTL

Master-side engine for the system bus: accepts one read/write command at a time on a valid/ready command port and drives the single-cycle `wen`/`ren` request. It waits for `ack`/`err` or a timeout, then returns read data and status on a valid/ready response port. It sits between command producers (debug bridge, DMA/config sequencers) and any system-bus slave, the initiator counterpart to the slave register blocks.

---
 rtl/sys_bus_pkg.sv | 15 +
 rtl/sys_bus_initiator_if.sv | 42 ++++
 rtl/sys_bus_initiator.sv | 114 +++++++++++
 3 files changed

// File: rtl/sys_bus_pkg.sv
// Shared system-bus definitions: response status encodings used by the
// initiator, the slave register blocks and their benches.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    STS_OK  = 2'b00,
    STS_ERR = 2'b01,
    STS_TMO = 2'b10
  } sys_bus_sts_t;

  localparam logic [1:0] SYS_STS_OK  = 2'b00;
  localparam logic [1:0] SYS_STS_ERR = 2'b01;
  localparam logic [1:0] SYS_STS_TMO = 2'b10;

endpackage

// File: rtl/sys_bus_initiator_if.sv
// Command, response and system-bus signal bundle for the bus initiator.
// master = initiator view, slave = producer/bus-slave/bench view.
interface sys_bus_initiator_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  import sys_bus_pkg::*;

  logic          cmd_vld;
  logic          cmd_rdy;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  sys_bus_sts_t  rsp_sts;

  logic          sys_wen;
  logic          sys_ren;
  logic [AW-1:0] sys_addr;
  logic [DW-1:0] sys_wdata;
  logic [DW-1:0] sys_rdata;
  logic          sys_ack;
  logic          sys_err;

  modport master (
    input  cmd_vld, cmd_wr, cmd_addr, cmd_wdata, rsp_rdy,
           sys_rdata, sys_ack, sys_err,
    output cmd_rdy, rsp_vld, rsp_rdata, rsp_sts,
           sys_wen, sys_ren, sys_addr, sys_wdata
  );

  modport slave (
    output cmd_vld, cmd_wr, cmd_addr, cmd_wdata, rsp_rdy,
           sys_rdata, sys_ack, sys_err,
    input  cmd_rdy, rsp_vld, rsp_rdata, rsp_sts,
           sys_wen, sys_ren, sys_addr, sys_wdata
  );

endinterface

// File: rtl/sys_bus_initiator.sv
// System-bus initiator: one command at a time, single-cycle wen/ren request,
// waits for ack/err or timeout, returns status and read data.
//
// state | meaning
// IDLE  | cmd_rdy high, waiting for a command
// REQ   | wen/ren pulse cycle; same-cycle ack/err is captured here
// WAIT  | waiting for ack/err, timeout counter running
// RESP  | response held on rsp_* until rsp_rdy
module sys_bus_initiator
  import sys_bus_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TOW     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  sys_bus_initiator_if.master bus,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t         state;
  logic [TOW-1:0] tmo_cnt;
  logic           wr_q;

  sys_bus_sts_t   cap_sts;
  logic [DW-1:0]  cap_rdata;
  logic           bus_done;

  // Response capture value when the slave answers: error wins, writes return 0.
  always_comb begin
    bus_done  = bus.sys_ack | bus.sys_err;
    cap_sts   = bus.sys_err ? STS_ERR : STS_OK;
    cap_rdata = wr_q ? {DW{1'b0}} : bus.sys_rdata;
  end

  // Sequencer: state, timeout counter and all registered outputs.
  // The counter holds the number of WAIT cycles including the current one,
  // so the compare hits TIMEOUT on the last WAIT cycle and a same-cycle ack
  // still takes precedence over the timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      wr_q          <= 1'b0;
      busy          <= 1'b0;
      bus.cmd_rdy   <= 1'b0;
      bus.rsp_vld   <= 1'b0;
      bus.rsp_rdata <= {DW{1'b0}};
      bus.rsp_sts   <= STS_OK;
      bus.sys_wen   <= 1'b0;
      bus.sys_ren   <= 1'b0;
      bus.sys_addr  <= {AW{1'b0}};
      bus.sys_wdata <= {DW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_rdy <= 1'b1;
          if (bus.cmd_vld && bus.cmd_rdy) begin
            bus.cmd_rdy   <= 1'b0;
            busy          <= 1'b1;
            wr_q          <= bus.cmd_wr;
            bus.sys_wen   <= bus.cmd_wr;
            bus.sys_ren   <= ~bus.cmd_wr;
            bus.sys_addr  <= bus.cmd_addr;
            bus.sys_wdata <= bus.cmd_wdata;
            state         <= REQ;
          end
        end
        REQ: begin
          bus.sys_wen <= 1'b0;
          bus.sys_ren <= 1'b0;
          tmo_cnt     <= TOW'(1);
          if (bus_done) begin
            bus.rsp_sts   <= cap_sts;
            bus.rsp_rdata <= cap_rdata;
            bus.rsp_vld   <= 1'b1;
            state         <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus_done) begin
            bus.rsp_sts   <= cap_sts;
            bus.rsp_rdata <= cap_rdata;
            bus.rsp_vld   <= 1'b1;
            state         <= RESP;
          end else if (TIMEOUT != 0 && tmo_cnt == TOW'(TIMEOUT)) begin
            bus.rsp_sts   <= STS_TMO;
            bus.rsp_rdata <= {DW{1'b0}};
            bus.rsp_vld   <= 1'b1;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_rdy) begin
            bus.rsp_vld <= 1'b0;
            bus.cmd_rdy <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
